// File: rtl/nibble_serial_addsub.sv
// nibble_serial_addsub
//   W-bit two's-complement add/subtract built from a single 4-bit
//   carry-lookahead slice that is reused over NIBBLES clock cycles, LSB
//   nibble first. The carry between nibbles lives in a register.
//
//   Optional feature (macro ADDSUB_SAT_EN):
//     defined   : on signed overflow the result saturates to the max
//                 positive / max negative value, chosen by the sign of
//                 the effective operand A. ovfl and cout are unchanged.
//     undefined : the result wraps modulo 2^W.
//
//   Handshake: the controller may raise start at any time. It is accepted
//   only on a rising edge where ready=1; a/b/op_sub are captured on that
//   edge and may change afterwards. done pulses for one cycle when
//   result/ovfl/cout have been updated. start in RUN/DONE is dropped.
//
//   Ports:
//     clk        in   1   rising-edge clock
//     rst_n      in   1   asynchronous active-low reset
//     start      in   1   operation request
//     op_sub     in   1   0 = a+b, 1 = a-b (sampled with start)
//     a, b       in   W   operands (sampled with start)
//     ready      out  1   idle, start will be accepted
//     done       out  1   one-cycle completion pulse
//     result     out  W   sum/difference, held until next completion
//     ovfl       out  1   signed overflow of last operation
//     cout       out  1   carry out of MSB (sub: 1 = no borrow)
//     dbg_state  out  2   current FSM state (debug observation)

// 4-bit carry-lookahead adder slice.
//   i_a, i_b : nibble operands      i_cin  : carry in
//   o_sum    : nibble sum           o_cout : carry out of bit 3
//   o_ovfl   : signed overflow of this nibble (carry into bit 3 ^ out)
module nibble_serial_addsub_cla4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout,
  output logic       o_ovfl
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_sum  = w_p ^ w_c[3:0];
  assign o_cout = w_c[4];
  assign o_ovfl = w_c[4] ^ w_c[3];
endmodule

module nibble_serial_addsub #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 op_sub,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 ready,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 ovfl,
  output logic                 cout,
  output logic [1:0]           dbg_state
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_carry;
  logic [W-1:0]  r_op_a;
  logic [W-1:0]  r_op_b;     // already inverted for subtraction
  logic [W-1:0]  r_work;
  logic [W-1:0]  r_result;
  logic          r_ovfl;
  logic          r_cout;

  logic [3:0]    w_a_nib;
  logic [3:0]    w_b_nib;
  logic [3:0]    w_sum;
  logic          w_cout;
  logic          w_ovfl;
  logic [W-1:0]  w_work_next;
  logic [W-1:0]  w_result_next;

  assign w_a_nib = r_op_a[r_cnt*4 +: 4];
  assign w_b_nib = r_op_b[r_cnt*4 +: 4];

  nibble_serial_addsub_cla4 u_cla (
    .i_a    (w_a_nib),
    .i_b    (w_b_nib),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout),
    .o_ovfl (w_ovfl)
  );

  // Work register with the current nibble merged in; on the last nibble
  // this is the complete word that goes to result.
  always_comb begin
    w_work_next = r_work;
    w_work_next[r_cnt*4 +: 4] = w_sum;
  end

`ifdef ADDSUB_SAT_EN
  // On overflow both effective operands share a sign; that sign decides
  // which end of the range to clamp to.
  always_comb begin
    w_result_next = w_work_next;
    if (w_ovfl) begin
      w_result_next = r_op_a[W-1] ? {1'b1, {(W-1){1'b0}}}
                                  : {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  assign w_result_next = w_work_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_work   <= '0;
      r_result <= '0;
      r_ovfl   <= 1'b0;
      r_cout   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op_a  <= a;
            r_op_b  <= op_sub ? ~b : b;
            // Subtraction is a + ~b + 1: the +1 enters as the first carry.
            r_carry <= op_sub;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_work  <= w_work_next;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_result <= w_result_next;
            r_ovfl   <= w_ovfl;
            r_cout   <= w_cout;
            r_cnt    <= '0;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready     = (r_state == S_IDLE);
  assign done      = (r_state == S_DONE);
  assign result    = r_result;
  assign ovfl      = r_ovfl;
  assign cout      = r_cout;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Bench for nibble_serial_addsub: reference model computes each operation
// with full-width arithmetic and tracks the busy window; a compare process
// checks every output on every falling edge. Directed literal cases pin
// the model; a randomized phase adds stray start pulses during busy.
module tb_nibble_serial_addsub;
  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic start;
  logic op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic ready;
  logic done;
  logic [W-1:0] result;
  logic ovfl;
  logic cout;
  logic [1:0] dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  nibble_serial_addsub #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .done      (done),
    .result    (result),
    .ovfl      (ovfl),
    .cout      (cout),
    .dbg_state (dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each entry: {cout, ovfl, result}
  logic [W+1:0] exp_q[$];
  int           m_busy;
  logic [W-1:0] m_res;
  logic         m_ovfl;
  logic         m_cout;

  function automatic logic [W+1:0] model_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub);
    logic [W-1:0] eb;
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         ov;
    eb = sub ? ~y : y;
    s  = {1'b0, x} + {1'b0, eb} + {{W{1'b0}}, sub};
    r  = s[W-1:0];
    ov = (x[W-1] == eb[W-1]) && (r[W-1] != x[W-1]);
`ifdef ADDSUB_SAT_EN
    if (ov) r = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return {s[W], ov, r};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0;
      m_res  = '0;
      m_ovfl = 1'b0;
      m_cout = 1'b0;
      exp_q.delete();
    end else if (m_busy == 0) begin
      if (start) begin
        exp_q.push_back(model_op(a, b, op_sub));
        m_busy = NIBBLES + 1;
      end
    end else begin
      m_busy = m_busy - 1;
      if (m_busy == 1) begin
        logic [W+1:0] e;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL model_queue: empty at completion");
        end else begin
          e = exp_q.pop_front();
          {m_cout, m_ovfl, m_res} = e;
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    check("ready",  {{(W-1){1'b0}}, ready}, {{(W-1){1'b0}}, (m_busy == 0)});
    check("done",   {{(W-1){1'b0}}, done},  {{(W-1){1'b0}}, (m_busy == 1)});
    check("result", result, m_res);
    check("ovfl",   {{(W-1){1'b0}}, ovfl},  {{(W-1){1'b0}}, m_ovfl});
    check("cout",   {{(W-1){1'b0}}, cout},  {{(W-1){1'b0}}, m_cout});
  end

  // ---------------- driver tasks ----------------
  task automatic drive_start(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts);
    @(posedge clk);
    #2;
    a = ta; b = tb_v; op_sub = ts; start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  // Issue one op from idle; optionally inject stray starts while busy.
  // Literal expectations checked at the done pulse and on busy length.
  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic ts, input bit lit, input logic [W-1:0] er,
                        input logic eo, input logic ec, input bit stray);
    int low_cnt;
    int n_done;
    bit back;
    logic [W-1:0] c_res;
    logic c_ov;
    logic c_co;
    logic [31:0] r32;
    low_cnt = 0; n_done = 0; back = 0;
    c_res = '0; c_ov = 1'b0; c_co = 1'b0;
    drive_start(ta, tb_v, ts);
    for (int i = 0; i < 4 * (NIBBLES + 2); i++) begin
      @(negedge clk);
      if (ready) begin back = 1; start = 1'b0; break; end
      low_cnt++;
      if (done) begin n_done++; c_res = result; c_ov = ovfl; c_co = cout; end
      if (stray) begin
        r32 = $urandom; a = r32[W-1:0];
        r32 = $urandom; b = r32[W-1:0];
        op_sub = r32[31];
        start = ($urandom_range(0, 2) == 0);
      end
    end
    if (!back) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: ready not seen within budget", name);
      start = 1'b0;
    end
    if (lit) begin
      check({name, "_res"},   c_res, er);
      check({name, "_ovfl"},  {{(W-1){1'b0}}, c_ov}, {{(W-1){1'b0}}, eo});
      check({name, "_cout"},  {{(W-1){1'b0}}, c_co}, {{(W-1){1'b0}}, ec});
      check({name, "_busy"},  W'(low_cnt), W'(NIBBLES + 1));
      check({name, "_ndone"}, W'(n_done), W'(1));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] r32;
    rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
    #1;
    check("reset_ready",  {{(W-1){1'b0}}, ready}, {{(W-1){1'b0}}, 1'b1});
    check("reset_done",   {{(W-1){1'b0}}, done},  '0);
    check("reset_result", result, '0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    run_op("add_1234_0fcd", 16'h1234, 16'h0FCD, 1'b0, 1, 16'h2201, 1'b0, 1'b0, 0);
`ifdef ADDSUB_SAT_EN
    run_op("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 1, 16'h7FFF, 1'b1, 1'b0, 0);
`else
    run_op("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 1, 16'h8000, 1'b1, 1'b0, 0);
`endif
    run_op("sub_5_7", 16'h0005, 16'h0007, 1'b1, 1, 16'hFFFE, 1'b0, 1'b0, 0);
`ifdef ADDSUB_SAT_EN
    run_op("sub_8000_1", 16'h8000, 16'h0001, 1'b1, 1, 16'h8000, 1'b1, 1'b1, 0);
`else
    run_op("sub_8000_1", 16'h8000, 16'h0001, 1'b1, 1, 16'h7FFF, 1'b1, 1'b1, 0);
`endif
    run_op("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 1, 16'h0000, 1'b0, 1'b1, 0);
    run_op("add_0_0",    16'h0000, 16'h0000, 1'b0, 1, 16'h0000, 1'b0, 1'b0, 0);

    // Second start during RUN must be ignored.
    begin
      int n_done;
      n_done = 0;
      drive_start(16'h0001, 16'h0002, 1'b0);
      @(posedge clk); #2;
      a = 16'h1111; b = 16'h1111; op_sub = 1'b0; start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      for (int i = 0; i < 3 * (NIBBLES + 2); i++) begin
        @(negedge clk);
        if (done) n_done++;
      end
      check("ignore_ndone",  W'(n_done), W'(1));
      check("ignore_result", result, 16'h0003);
    end

    // Reset in the middle of an operation.
    run_op("pre_rst", 16'h1234, 16'h0FCD, 1'b0, 1, 16'h2201, 1'b0, 1'b0, 0);
    drive_start(16'h00FF, 16'h0001, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ready",  {{(W-1){1'b0}}, ready}, {{(W-1){1'b0}}, 1'b1});
    check("midrst_done",   {{(W-1){1'b0}}, done},  '0);
    check("midrst_result", result, '0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    run_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 1, 16'h0100, 1'b0, 1'b0, 0);

    // Randomized traffic with stray start pulses while busy.
    for (int n = 0; n < 300; n++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      r32 = $urandom; ra = r32[W-1:0];
      r32 = $urandom; rb = r32[W-1:0];
      case ($urandom_range(0, 5))
        0: ra = {1'b0, {(W-1){1'b1}}};
        1: rb = {1'b1, {(W-1){1'b0}}};
        default: ;
      endcase
      run_op("rand", ra, rb, r32[31], 0, '0, 1'b0, 1'b0, ($urandom_range(0, 1) == 1));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
